// File: rtl/fifo_push_arbiter.sv
// Purpose : two-producer round-robin write arbiter in front of a DEPTH-entry circular FIFO
// Latency : grants are combinational; read data/tag are registered, valid one cycle after pop
// Backpressure: no grant while full; a non-granted producer holds req/data; pop on empty is ignored
//
// Ports:
//   clk, reset              - single clock, synchronous active-high reset
//   req0/data0, req1/data1  - producer write requests and data
//   gnt0, gnt1              - write accepted this cycle (combinational, one-hot or zero)
//   pop                     - consumer read request
//   data_out, src_out       - registered read data and its source tag (0 = producer 0)
//   data_valid              - one-cycle pulse marking fresh data_out/src_out
//   count                   - occupancy 0..DEPTH
//   fifo_full, fifo_empty   - decoded from the registered count
module fifo_push_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             src_out,
  output logic             data_valid,
  output logic [AW:0]      count,
  output logic             fifo_full,
  output logic             fifo_empty
);

  // Each entry carries the source tag above the data bits.
  logic [WIDTH:0] mem [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          prio;
  logic          push;
  logic          pop_ok;
  logic [WIDTH:0] wr_entry;

  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);

  // Grant decode: full blocks everything (even with a concurrent pop, so
  // there is no push-through); a lone requester wins; a tie goes to prio.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!fifo_full) begin
      if (req0 && req1) begin
        gnt0 = ~prio;
        gnt1 = prio;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign push     = gnt0 | gnt1;
  assign pop_ok   = pop & ~fifo_empty;
  assign wr_entry = gnt1 ? {1'b1, data1} : {1'b0, data0};

  // Storage has no reset; occupancy is tracked by count/pointers only.
  // A reset cycle suppresses the write so discarded traffic never lands.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wp] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      prio       <= 1'b0;
      data_out   <= '0;
      src_out    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      // Round-robin: whoever was just served loses the next tie.
      if (gnt0) begin
        prio <= 1'b1;
      end else if (gnt1) begin
        prio <= 1'b0;
      end

      if (push) begin
        wp <= wp + AW'(1);
      end

      // A pop on an empty FIFO is dropped even if a push lands this edge;
      // the pushed entry becomes readable from the next cycle on.
      data_valid <= pop_ok;
      if (pop_ok) begin
        {src_out, data_out} <= mem[rp];
        rp <= rp + AW'(1);
      end

      case ({push, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Purpose : directed table-driven bench for fifo_push_arbiter plus a hand-written prio sequence
// Latency : grants checked mid-cycle, registered outputs checked 1 time unit after each edge
// Backpressure: stimulus holds req/data on non-granted cycles as the producer contract requires
module tb_fifo_push_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, pop;
  logic [3:0] data0, data1;
  logic       gnt0, gnt1;
  logic [3:0] data_out;
  logic       src_out;
  logic       data_valid;
  logic [2:0] count;
  logic       fifo_full, fifo_empty;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fifo_push_arbiter #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .req1       (req1),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .pop        (pop),
    .data_out   (data_out),
    .src_out    (src_out),
    .data_valid (data_valid),
    .count      (count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  // One cycle of stimulus: gnt expectations hold during the cycle, the rest
  // describe the registered outputs right after the closing edge.
  typedef struct {
    bit       rst;
    bit       r0;
    bit [3:0] d0;
    bit       r1;
    bit [3:0] d1;
    bit       p;
    bit       g0;
    bit       g1;
    int       cnt;
    bit       vld;
    bit [3:0] dout;
    bit       src;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit r0, bit [3:0] d0, bit r1, bit [3:0] d1, bit p,
                              bit g0, bit g1, int cnt, bit vld, bit [3:0] dout, bit src);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.p = p;
    v.g0 = g0; v.g1 = g1; v.cnt = cnt; v.vld = vld; v.dout = dout; v.src = src;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset = v.rst; req0 = v.r0; data0 = v.d0; req1 = v.r1; data1 = v.d1; pop = v.p;
    #2;
    check("gnt0", idx, {7'd0, gnt0}, {7'd0, v.g0});
    check("gnt1", idx, {7'd0, gnt1}, {7'd0, v.g1});
    @(posedge clk);
    #1;
    check("count",      idx, {5'd0, count},      8'(v.cnt));
    check("fifo_empty", idx, {7'd0, fifo_empty}, {7'd0, v.cnt == 0});
    check("fifo_full",  idx, {7'd0, fifo_full},  {7'd0, v.cnt == 4});
    check("data_valid", idx, {7'd0, data_valid}, {7'd0, v.vld});
    check("data_out",   idx, {4'd0, data_out},   {4'd0, v.dout});
    check("src_out",    idx, {7'd0, src_out},    {7'd0, v.src});
    n_vec++;
  endtask

  initial begin
    //                 rst r0 d0    r1 d1    p   g0 g1 cnt vld dout  src
    // reset, then pop while empty
    vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0,  0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 0,  0, 4'h0, 0));
    // single producer fills to full, fifth request refused
    vecs.push_back(mk(0, 1, 4'hA, 0, 4'h0, 0,  1, 0, 1,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 0, 4'h0, 0,  1, 0, 2,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 0, 4'h0, 0,  1, 0, 3,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 0, 4'h0, 0,  1, 0, 4,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 0, 4'h0, 0,  0, 0, 4,  0, 4'h0, 0));
    // drain
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 3,  1, 4'hA, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 2,  1, 4'hA, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1,  1, 4'hA, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 0,  1, 4'hA, 0));
    // reset clears data_out; both request -> alternate from producer 0
    vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 1, 4'h2, 0,  1, 0, 1,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 1, 4'h2, 0,  0, 1, 2,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 1, 4'h2, 0,  1, 0, 3,  0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 1, 4'h2, 0,  0, 1, 4,  0, 4'h0, 0));
    // pops return tagged entries in order; valid is a single-cycle pulse
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 3,  1, 4'h1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 3,  0, 4'h1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 2,  1, 4'h2, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1,  1, 4'h1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 0,  1, 4'h2, 1));
    // three entries from producer 0
    vecs.push_back(mk(0, 1, 4'h3, 0, 4'h0, 0,  1, 0, 1,  0, 4'h2, 1));
    vecs.push_back(mk(0, 1, 4'h4, 0, 4'h0, 0,  1, 0, 2,  0, 4'h2, 1));
    vecs.push_back(mk(0, 1, 4'h5, 0, 4'h0, 0,  1, 0, 3,  0, 4'h2, 1));
    // steady push+pop for six cycles, pointers wrap
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h6, 1,  0, 1, 3,  1, 4'h3, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h7, 1,  0, 1, 3,  1, 4'h4, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h8, 1,  0, 1, 3,  1, 4'h5, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h9, 1,  0, 1, 3,  1, 4'h6, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'hA, 1,  0, 1, 3,  1, 4'h7, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'hB, 1,  0, 1, 3,  1, 4'h8, 1));
    // reach full, then push+pop while full: push refused, pop served
    vecs.push_back(mk(0, 1, 4'hC, 0, 4'h0, 0,  1, 0, 4,  0, 4'h8, 1));
    vecs.push_back(mk(0, 1, 4'hD, 0, 4'h0, 1,  0, 0, 3,  1, 4'h9, 1));
    vecs.push_back(mk(0, 1, 4'hD, 0, 4'h0, 0,  1, 0, 4,  0, 4'h9, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 3,  1, 4'hA, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 2,  1, 4'hB, 1));
    // reset with req1 and pop high: grant is visible but nothing lands
    vecs.push_back(mk(1, 0, 4'h0, 1, 4'hE, 1,  0, 1, 0,  0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 0,  0, 4'h0, 0));
    // push and pop together on empty: pop dropped, push lands
    vecs.push_back(mk(0, 1, 4'h5, 0, 4'h0, 1,  1, 0, 1,  0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 0,  1, 4'h5, 0));

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; pop = 1'b0; data0 = '0; data1 = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Priority must hold across idle cycles: producer 0 wins alone, then
    // after an idle cycle the tie goes to producer 1.
    apply(mk(1, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 0), 100);
    apply(mk(0, 1, 4'h7, 0, 4'h0, 0,  1, 0, 1, 0, 4'h0, 0), 101);
    apply(mk(0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 1, 0, 4'h0, 0), 102);
    apply(mk(0, 1, 4'h7, 1, 4'h9, 0,  0, 1, 2, 0, 4'h0, 0), 103);
    apply(mk(0, 1, 4'h7, 1, 4'h9, 1,  1, 0, 2, 1, 4'h7, 0), 104);
    apply(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 1, 4'h9, 1), 105);
    apply(mk(0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 0, 1, 4'h7, 0), 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Two-producer round-robin arbiter in front of a single circular FIFO. Each cycle it grants at most one requester's write into shared storage and serves one consumer pop, returning the data with its source tag. It sits between two 4-bit data sources and one downstream consumer. It replaces direct, unarbitrated push into the shift-register FIFO.

## Interface

Parameters:
- WIDTH, 4 — data width per entry
- DEPTH, 4 — number of entries; power of two, ≥ 2
- AW, 2 — pointer width, log2(DEPTH)

Ports:
- clk  input  1  — single clock; all state updates on its rising edge
- reset  input  1  — synchronous, active-high; sampled on the rising edge of clk
- req0  input  1  — producer 0 write request
- data0  input  WIDTH  — producer 0 write data
- req1  input  1  — producer 1 write request
- data1  input  WIDTH  — producer 1 write data
- gnt0  output  1  — producer 0 write accepted this cycle (combinational)
- gnt1  output  1  — producer 1 write accepted this cycle (combinational)
- pop  input  1  — consumer read request
- data_out  output  WIDTH  — read data (registered)
- src_out  output  1  — source tag of data_out: 0 = producer 0, 1 = producer 1 (registered)
- data_valid  output  1  — one-cycle pulse; data_out and src_out are new this cycle
- count  output  AW+1  — current occupancy, 0..DEPTH
- fifo_full  output  1  — count == DEPTH
- fifo_empty  output  1  — count == 0

## Operation

- Storage: DEPTH entries of {tag, data}. Write pointer wp and read pointer rp are AW bits wide and wrap modulo DEPTH.
- Arbitration uses a priority register prio; 0 favours producer 0.
  - If fifo_full is high, gnt0 = gnt1 = 0 regardless of requests.
  - Otherwise, if exactly one req is high, that producer is granted.
  - Otherwise, if both are high, the producer selected by prio is granted.
  - At most one gnt is high in any cycle.
- prio update on the edge:
  - If gnt0 fired, prio ← 1.
  - If gnt1 fired, prio ← 0.
  - If no grant fired, prio holds.
- Push on the edge when a gnt fires:
  - mem[wp] ← {tag, data of the granted producer}
  - wp ← wp+1
- Pop on the edge when pop & !fifo_empty:
  - {src_out, data_out} ← mem[rp]
  - rp ← rp+1
  - data_valid ← 1
- When no pop is accepted: data_valid ← 0, and data_out/src_out hold their previous values.
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop, or on neither
- fifo_full blocks a push even if a pop occurs in the same cycle. No push-through when full.
- pop while empty is ignored: no pointer change, data_valid stays 0.
- fifo_full and fifo_empty are decoded combinationally from the registered count.
- A non-granted producer must hold its req and data. The block has no request queueing.

## Timing

- Reset (synchronous, takes effect on the edge where reset = 1):
  - wp = rp = 0, count = 0, prio = 0
  - data_out = 0, src_out = 0, data_valid = 0
  - fifo_empty = 1, fifo_full = 0, gnt0 = gnt1 = 0 unless requested
- Storage contents are not cleared by reset.
- Reset mid-operation overrides push and pop in the same cycle. All held entries are discarded.
- gnt is valid in the same cycle as req: combinational from req0, req1, fifo_full and prio.
- Write-to-flag latency: fifo_empty falls in the cycle after the push edge.
- Read latency: 1 cycle. A pop sampled at edge N produces data_valid = 1 and valid data during cycle N+1.
- Simultaneous push and pop on an empty FIFO:
  - The pop is ignored.
  - The push lands.
  - count becomes 1.
- Wrap-around: after DEPTH pushes and DEPTH pops, both pointers return to 0. FIFO order is preserved across the wrap.

## Test plan

- Reset, then pulse pop with the FIFO empty → data_valid stays 0, count = 0, fifo_empty = 1.
- req0 with data0 = 4'hA for 4 consecutive cycles, req1 = 0 → gnt0 high each cycle, count reaches 4, fifo_full = 1. A 5th req0 cycle → gnt0 = 0, count stays 4.
- req0 = req1 = 1 continuously, data0 = 4'h1, data1 = 4'h2, starting from reset → grants alternate gnt0, gnt1, gnt0, gnt1. Four pops then return (1,tag0), (2,tag1), (1,tag0), (2,tag1), each with data_valid exactly one cycle after its pop.
- Fill with 3 entries, then assert req1 and pop together for 6 cycles → count holds at 3 and data_valid is high every cycle. Pointers wrap past index 3 with order intact.
- Full FIFO, then req0 and pop in the same cycle → gnt0 = 0, count becomes 3. Next cycle → gnt0 = 1.
- Two entries held, then assert reset for one cycle with req1 and pop also high → count = 0, fifo_empty = 1, data_valid = 0, data_out = 0 after the edge. No entry is pushed.
